// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared types and constants for the ADC capture controller.
//   cap_state_e  - capture sequencer states
//   TRUNC_*      - clip-flag codes carried alongside each sample
//   OVR_CNT_MAX  - saturation value of the clipped-sample counter
package adc_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } cap_state_e;

    localparam logic [1:0] TRUNC_NONE = 2'b00;
    localparam logic [1:0] TRUNC_LOW  = 2'b01;
    localparam logic [1:0] TRUNC_HIGH = 2'b10;

    localparam logic [7:0] OVR_CNT_MAX = 8'd255;

endpackage

// File: rtl/adc_cap_buf.sv
// adc_cap_buf: simple dual-port capture RAM, DEPTH x DW.
//   clk, rst_n               - clock, async active-low reset (read register only)
//   wr_en, wr_addr, wr_dat   - write port
//   rd_en, rd_addr -> rd_dat - registered read, data one cycle after rd_en
// Memory contents are not reset; only the read register is cleared.
module adc_cap_buf #(
    parameter int DEPTH = 1024,
    parameter int DW    = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_dat <= '0;
        else if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: armed/triggered capture of a scaled ADC sample stream into
// a local buffer, followed by sample-at-a-time readout.
//   clk, rst_n                     - clock, async active-low reset
//   smp_dat, smp_trunc, smp_vld    - incoming sample stream with clip flags
//   arm                            - (re)start a capture sequence, latches cap_len
//   sw_trig                        - software trigger, honoured only while armed
//   cap_len                        - samples per capture, 0 selects DEPTH
//   trig_level                     - rising-edge level threshold
//   rd_req -> rd_dat, rd_vld       - buffered sample readout, 1-cycle latency
//   busy, done, ovr_cnt            - status and saturating clipped-sample count
// Build option: define ADC_CAP_LEVEL_TRIG_EN to enable the level trigger;
// otherwise only sw_trig starts a capture and trig_level is ignored.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int DW    = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] smp_dat,
    input  logic [1:0]    smp_trunc,
    input  logic          smp_vld,
    input  logic          arm,
    input  logic          sw_trig,
    input  logic [AW-1:0] cap_len,
    input  logic [DW-1:0] trig_level,
    input  logic          rd_req,
    output logic [DW-1:0] rd_dat,
    output logic          rd_vld,
    output logic          busy,
    output logic          done,
    output logic [7:0]    ovr_cnt
);

    cap_state_e state, state_nxt;

    // Pointers and length carry one extra bit so a full DEPTH capture is representable.
    logic [AW:0] len_q, wr_ptr, rd_ptr;
    logic        trig, wr_en, wr_last, rd_fire, lvl_hit;

`ifdef ADC_CAP_LEVEL_TRIG_EN
    // History of the previous valid sample while armed; cleared on arm so the
    // first sample after arming can never produce a rising edge.
    logic [DW-1:0] prev_dat;
    logic          prev_vld;

    assign lvl_hit = smp_vld && prev_vld && (prev_dat < trig_level) && (smp_dat >= trig_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vld <= 1'b0;
            prev_dat <= '0;
        end else if (arm) begin
            prev_vld <= 1'b0;
        end else if (state == ST_ARMED && smp_vld) begin
            prev_vld <= 1'b1;
            prev_dat <= smp_dat;
        end
    end
`else
    logic unused_trig_level;
    assign unused_trig_level = ^trig_level;
    assign lvl_hit           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        trig      = 1'b0;
        wr_en     = 1'b0;
        rd_fire   = 1'b0;
        wr_last   = 1'b0;
        case (state)
            ST_ARMED: begin
                trig  = sw_trig | lvl_hit;
                wr_en = trig & smp_vld;    // triggering sample lands at index 0
            end
            ST_CAPTURE: wr_en   = smp_vld;
            ST_READOUT: rd_fire = rd_req && (rd_ptr < len_q);
            default: ;
        endcase
        // arm overrides any trigger, write or read in the same cycle
        if (arm) begin
            wr_en   = 1'b0;
            rd_fire = 1'b0;
        end
        wr_last = wr_en && ((wr_ptr + 1'b1) == len_q);

        if (state == ST_ARMED && trig)                state_nxt = ST_CAPTURE;
        if (wr_last)                                  state_nxt = ST_READOUT;
        if (state == ST_READOUT && rd_ptr == len_q)   state_nxt = ST_IDLE;
        if (arm)                                      state_nxt = ST_ARMED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovr_cnt <= '0;
            done    <= 1'b0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_fire;
            if (arm) begin
                len_q   <= (cap_len == '0) ? (AW+1)'(DEPTH) : {1'b0, cap_len};
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                ovr_cnt <= '0;
                done    <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (smp_trunc != TRUNC_NONE && ovr_cnt != OVR_CNT_MAX)
                        ovr_cnt <= ovr_cnt + 8'd1;
                end
                if (wr_last) done   <= 1'b1;
                if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign busy = (state == ST_ARMED) || (state == ST_CAPTURE);

    adc_cap_buf #(.DEPTH(DEPTH), .DW(DW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_dat  (smp_dat),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_dat  (rd_dat)
    );

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning capture buffer depth in samples (power of 2).
REQ-002 SHALL have parameter DW, default 12, meaning scaled sample width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port smp_dat  input  DW  scaled ADC sample.
REQ-006 SHALL have port smp_trunc  input  2  clip flags aligned with smp_dat: 01 low clip, 10 high clip, 00 none.
REQ-007 SHALL have port smp_vld  input  1  smp_dat/smp_trunc valid this cycle.
REQ-008 SHALL have port arm  input  1  single-cycle pulse starting a capture sequence.
REQ-009 SHALL have port sw_trig  input  1  single-cycle software trigger.
REQ-010 SHALL have port cap_len  input  log2(DEPTH)  samples per capture; 0 means DEPTH.
REQ-011 SHALL have port trig_level  input  DW  rising-edge level threshold.
REQ-012 SHALL have port rd_req  input  1  read one buffered sample.
REQ-013 SHALL have port rd_dat  output  DW  read sample; rd_vld  output  1  rd_dat valid.
REQ-014 SHALL have ports busy, done  output  1 each; ovr_cnt  output  8  clipped-sample count.

Function
REQ-015 SHALL implement FSM IDLE, ARMED, CAPTURE, READOUT.
REQ-016 IDLE: arm -> ARMED next cycle; cap_len latched, wr_ptr, rd_ptr, ovr_cnt cleared, done cleared.
REQ-017 ARMED: trigger when sw_trig=1, or smp_vld=1 with previous valid sample < trig_level and current >= trig_level (unsigned) -> CAPTURE.
REQ-018 Triggering sample (if smp_vld in trigger cycle) SHALL be written as buffer index 0; otherwise first valid sample after trigger.
REQ-019 CAPTURE: each smp_vld writes smp_dat at wr_ptr, wr_ptr+1; after latched length written -> READOUT, done=1 same edge.
REQ-020 ovr_cnt SHALL increment per written sample with smp_trunc!=00, saturating at 255; unchanged in other states.
REQ-021 READOUT: rd_req with rd_ptr < length -> rd_dat=buffer[rd_ptr], rd_vld=1 exactly one cycle later; rd_ptr+1.
REQ-022 rd_req ignored outside READOUT or when rd_ptr = length; back-to-back rd_req SHALL give one sample per cycle.
REQ-023 After final rd_vld -> IDLE; done stays 1 until next arm.
REQ-024 busy=1 in ARMED and CAPTURE, 0 otherwise.
REQ-025 arm in ARMED, CAPTURE or READOUT SHALL abort and restart as REQ-016; arm wins over simultaneous trigger/completion.
REQ-026 sw_trig outside ARMED SHALL be ignored; level-detector history reset on entering ARMED (first sample cannot trigger).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, busy=0, done=0, rd_vld=0, rd_dat=0, ovr_cnt=0, pointers 0; buffer contents undefined.
REQ-028 Reset mid-capture/readout SHALL discard the sequence; no rd_vld after release until new capture.

Configuration
REQ-029 Macro ADC_CAP_LEVEL_TRIG_EN defined: level trigger per REQ-017 active.
REQ-030 Macro undefined: only sw_trig triggers; trig_level unused; no comparator/history logic.

Structure
REQ-031 Package adc_cap_pkg SHALL hold FSM state enum, trunc code constants (TRUNC_NONE/LOW/HIGH), OVR_CNT_MAX.
REQ-032 Sub-module adc_cap_buf: simple dual-port RAM, DEPTH x DW, one write port, registered read (1-cycle latency).

Verification
REQ-033 arm, cap_len=4, sw_trig, samples 10,20,30,40 valid -> done=1 after 4th; four rd_req -> rd_dat 10,20,30,40, each 1 cycle after req.
REQ-034 Level trig, trig_level=2000, samples 1990,2010 -> capture starts at 2010 (index 0); samples 2010,1990 after arm -> no trigger on first.
REQ-035 cap_len=8, 3 samples with smp_trunc=10 and 1 with 01 -> ovr_cnt=4; 300 clipped samples at DEPTH -> ovr_cnt=255.
REQ-036 cap_len=0 -> exactly 1024 samples captured, rd_ptr wraps not past 1023; 1025th rd_req ignored.
REQ-037 arm during CAPTURE after 2 samples -> ARMED, ovr_cnt=0, done=0; rst_n low during READOUT -> rd_vld=0, IDLE.
REQ-038 Macro undefined, sample crossing trig_level -> stays ARMED until sw_trig.
